// File: rtl/otter_mem_arb_pkg.sv
// Shared types for the OTTER memory port-2 arbiter: FSM states, owner tags,
// access-size codes and the latched command that drives the memory port.
package otter_mem_arb_pkg;

    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    typedef struct packed {
        logic                  we;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] din;
        logic [1:0]            size;
        logic                  sign;
    } cmd_t;

endpackage

// File: rtl/otter_mem_port2_arbiter.sv
// Shares OTTER memory port 2 between the CPU MEM stage (A) and the serial
// programmer (B), sequencing each access around the 1-cycle registered read.
module otter_mem_port2_arbiter
    import otter_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = CMD_ADDR_W,
    parameter int DATA_WIDTH = CMD_DATA_W
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  PROG_LOCK,
    input  logic                  A_REQ,
    input  logic                  B_REQ,
    input  logic                  A_WE,
    input  logic                  B_WE,
    input  logic [ADDR_WIDTH-1:0] A_ADDR,
    input  logic [ADDR_WIDTH-1:0] B_ADDR,
    input  logic [DATA_WIDTH-1:0] A_DIN,
    input  logic [DATA_WIDTH-1:0] B_DIN,
    input  logic [1:0]            A_SIZE,
    input  logic [1:0]            B_SIZE,
    input  logic                  A_SIGN,
    input  logic                  B_SIGN,
    output logic                  A_GNT,
    output logic                  B_GNT,
    output logic                  A_RVALID,
    output logic                  B_RVALID,
    output logic [DATA_WIDTH-1:0] A_RDATA,
    output logic [DATA_WIDTH-1:0] B_RDATA,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR2,
    output logic [DATA_WIDTH-1:0] MEM_DIN2,
    output logic                  MEM_WRITE2,
    output logic                  MEM_READ2,
    output logic [1:0]            MEM_SIZE,
    output logic                  MEM_SIGN,
    input  logic [DATA_WIDTH-1:0] MEM_DOUT2,
    output logic                  BUSY
);

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    owner_e last_owner_q, last_owner_d;
    cmd_t   cmd_q, cmd_d;

    logic port_free;
    logic elig_a, elig_b;
    logic pick_a, pick_b;
    logic gnt_a, gnt_b;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            owner_q      <= OWN_A;
            last_owner_q <= OWN_B;
            cmd_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cmd_q        <= cmd_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cmd_d        = cmd_q;

        // A write finishes in ISSUE, so the port can take a new command then.
        port_free = (state_q == IDLE) || (state_q == RESP) ||
                    ((state_q == ISSUE) && cmd_q.we);

        elig_a = A_REQ && !PROG_LOCK;
        elig_b = B_REQ;
        pick_a = elig_a && (!elig_b || (last_owner_q == OWN_B));
        pick_b = elig_b && !pick_a;

        // Grants are masked during reset so no requester sees a phantom accept.
        gnt_a = RST_N && port_free && pick_a;
        gnt_b = RST_N && port_free && pick_b;

        if (port_free) begin
            if (gnt_a) begin
                state_d      = ISSUE;
                owner_d      = OWN_A;
                last_owner_d = OWN_A;
                cmd_d        = '{we: A_WE, addr: A_ADDR, din: A_DIN,
                                 size: A_SIZE, sign: A_SIGN};
            end else if (gnt_b) begin
                state_d      = ISSUE;
                owner_d      = OWN_B;
                last_owner_d = OWN_B;
                cmd_d        = '{we: B_WE, addr: B_ADDR, din: B_DIN,
                                 size: B_SIZE, sign: B_SIGN};
            end else begin
                state_d = IDLE;
            end
        end else begin
            state_d = RESP;
        end
    end

    assign A_GNT = gnt_a;
    assign B_GNT = gnt_b;

    // Address/size/sign stay on the port through RESP for the memory's slicer.
    assign MEM_ADDR2  = cmd_q.addr;
    assign MEM_DIN2   = cmd_q.din;
    assign MEM_SIZE   = cmd_q.size;
    assign MEM_SIGN   = cmd_q.sign;
    assign MEM_WRITE2 = (state_q == ISSUE) && cmd_q.we;
    assign MEM_READ2  = (state_q == ISSUE) && !cmd_q.we;
    assign BUSY       = (state_q != IDLE);

    assign A_RVALID = (state_q == RESP) && (owner_q == OWN_A);
    assign B_RVALID = (state_q == RESP) && (owner_q == OWN_B);
    assign A_RDATA  = A_RVALID ? MEM_DOUT2 : '0;
    assign B_RDATA  = B_RVALID ? MEM_DOUT2 : '0;

endmodule

// File: tb/tb_otter_mem_port2_arbiter.sv
// Directed bench for the port-2 arbiter with a small word memory model that
// mimics the OTTER registered read and live-address data slicing.
module tb_otter_mem_port2_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        PROG_LOCK;
    logic        A_REQ, B_REQ, A_WE, B_WE, A_SIGN, B_SIGN;
    logic [31:0] A_ADDR, B_ADDR, A_DIN, B_DIN;
    logic [1:0]  A_SIZE, B_SIZE;
    logic        A_GNT, B_GNT, A_RVALID, B_RVALID;
    logic [31:0] A_RDATA, B_RDATA, MEM_ADDR2, MEM_DIN2, MEM_DOUT2;
    logic        MEM_WRITE2, MEM_READ2, MEM_SIGN, BUSY;
    logic [1:0]  MEM_SIZE;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:255];
    logic [31:0] rd_word;

    always #5 CLK = ~CLK;

    otter_mem_port2_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .PROG_LOCK(PROG_LOCK),
        .A_REQ(A_REQ), .B_REQ(B_REQ), .A_WE(A_WE), .B_WE(B_WE),
        .A_ADDR(A_ADDR), .B_ADDR(B_ADDR), .A_DIN(A_DIN), .B_DIN(B_DIN),
        .A_SIZE(A_SIZE), .B_SIZE(B_SIZE), .A_SIGN(A_SIGN), .B_SIGN(B_SIGN),
        .A_GNT(A_GNT), .B_GNT(B_GNT), .A_RVALID(A_RVALID), .B_RVALID(B_RVALID),
        .A_RDATA(A_RDATA), .B_RDATA(B_RDATA),
        .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_WRITE2(MEM_WRITE2),
        .MEM_READ2(MEM_READ2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
        .MEM_DOUT2(MEM_DOUT2), .BUSY(BUSY)
    );

    function automatic logic [31:0] slice(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'd0:    return uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'd1:    return uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    // Word-wide memory model; contents are loaded while reset is held.
    always @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[64] <= 32'hDEADBEEF;
            rd_word <= 32'h0;
        end else begin
            if (MEM_WRITE2) mem[MEM_ADDR2[9:2]] <= MEM_DIN2;
            if (MEM_READ2)  rd_word <= mem[MEM_ADDR2[9:2]];
        end
    end

    assign MEM_DOUT2 = slice(rd_word, MEM_ADDR2[1:0], MEM_SIZE, MEM_SIGN);

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] din);
        A_REQ = req; A_WE = we; A_ADDR = addr; A_DIN = din;
        A_SIZE = 2'd2; A_SIGN = 1'b0;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] din);
        B_REQ = req; B_WE = we; B_ADDR = addr; B_DIN = din;
        B_SIZE = 2'd2; B_SIGN = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_data [0:3];
        logic [31:0] exp_addr [0:3];
        RST_N = 1'b0;
        PROG_LOCK = 1'b0;
        set_a(1'b1, 1'b0, 32'h100, 32'h0);
        set_b(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset held two cycles while A requests.
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_a_gnt", A_GNT, 0);
            check("rst_mem_addr", MEM_ADDR2, 0);
            check("rst_mem_ctl", {MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN}, 0);
            check("rst_mem_din", MEM_DIN2, 0);
            check("rst_busy", BUSY, 0);
            check("rst_rvalid", {A_RVALID, B_RVALID}, 0);
        end
        RST_N = 1'b1;
        #1;
        check("rel_a_gnt", A_GNT, 1);
        check("rel_b_gnt", B_GNT, 0);

        // Single word read of 0x100.
        tick();
        set_a(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("rd_mem_read", MEM_READ2, 1);
        check("rd_mem_addr", MEM_ADDR2, 32'h100);
        check("rd_busy", BUSY, 1);
        check("rd_early_rvalid", A_RVALID, 0);
        tick();
        check("rd_a_rvalid", A_RVALID, 1);
        check("rd_a_rdata", A_RDATA, 32'hDEADBEEF);
        check("rd_addr_held", MEM_ADDR2, 32'h100);
        check("rd_resp_read", MEM_READ2, 0);
        check("rd_b_rvalid", B_RVALID, 0);
        tick();
        check("rd_done_rvalid", A_RVALID, 0);
        check("rd_done_rdata", A_RDATA, 0);
        check("rd_done_busy", BUSY, 0);

        // Three back-to-back writes from A.
        for (int i = 0; i < 4; i++) begin
            if (i < 3) set_a(1'b1, 1'b1, 32'h10 + 32'(4 * i), 32'(i + 1));
            else       set_a(1'b0, 1'b0, 32'h0, 32'h0);
            #1;
            check("wr_a_gnt", A_GNT, (i < 3) ? 1 : 0);
            if (i > 0) begin
                check("wr_mem_write", MEM_WRITE2, 1);
                check("wr_mem_addr", MEM_ADDR2, 32'h10 + 32'(4 * (i - 1)));
                check("wr_mem_din", MEM_DIN2, 32'(i));
            end
            tick();
        end
        check("wr_done_write", MEM_WRITE2, 0);
        check("wr_done_busy", BUSY, 0);

        // Read the three words back.
        for (int i = 0; i < 3; i++) begin
            set_a(1'b1, 1'b0, 32'h10 + 32'(4 * i), 32'h0);
            #1;
            check("rb_a_gnt", A_GNT, 1);
            tick();
            set_a(1'b0, 1'b0, 32'h0, 32'h0);
            tick();
            check("rb_rvalid", A_RVALID, 1);
            check("rb_rdata", A_RDATA, 32'(i + 1));
            tick();
        end

        // Lone B write so B becomes the last owner.
        set_b(1'b1, 1'b1, 32'h20, 32'h77);
        #1;
        check("bw_b_gnt", B_GNT, 1);
        tick();
        set_b(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("bw_mem_write", MEM_WRITE2, 1);
        check("bw_mem_din", MEM_DIN2, 32'h77);
        tick();

        // Contention: both hold reads; expect A, B, A, B.
        exp_addr[0] = 32'h10; exp_data[0] = 32'h1;
        exp_addr[1] = 32'h20; exp_data[1] = 32'h77;
        exp_addr[2] = 32'h10; exp_data[2] = 32'h1;
        exp_addr[3] = 32'h20; exp_data[3] = 32'h77;
        set_a(1'b1, 1'b0, 32'h10, 32'h0);
        set_b(1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        for (int g = 0; g < 4; g++) begin
            check("ct_a_gnt", A_GNT, (g % 2 == 0) ? 1 : 0);
            check("ct_b_gnt", B_GNT, (g % 2 == 1) ? 1 : 0);
            if (g > 0) begin
                check("ct_a_rvalid", A_RVALID, (g % 2 == 1) ? 1 : 0);
                check("ct_b_rvalid", B_RVALID, (g % 2 == 0) ? 1 : 0);
                check("ct_rdata", A_RDATA | B_RDATA, exp_data[g - 1]);
            end
            tick();
            if (g == 3) begin
                set_a(1'b0, 1'b0, 32'h0, 32'h0);
                set_b(1'b0, 1'b0, 32'h0, 32'h0);
            end
            #1;
            check("ct_issue_gnt", {A_GNT, B_GNT}, 0);
            check("ct_issue_read", MEM_READ2, 1);
            check("ct_issue_addr", MEM_ADDR2, exp_addr[g]);
            tick();
        end
        check("ct_last_b_rvalid", B_RVALID, 1);
        check("ct_last_a_rvalid", A_RVALID, 0);
        check("ct_last_rdata", B_RDATA, 32'h77);
        tick();

        // PROG_LOCK blocks A while B writes 0x200.
        PROG_LOCK = 1'b1;
        set_b(1'b1, 1'b1, 32'h200, 32'h55);
        set_a(1'b1, 1'b0, 32'h200, 32'h0);
        #1;
        check("lk_b_gnt", B_GNT, 1);
        check("lk_a_gnt", A_GNT, 0);
        tick();
        set_b(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("lk_issue_a_gnt", A_GNT, 0);
        check("lk_mem_write", MEM_WRITE2, 1);
        check("lk_mem_addr", MEM_ADDR2, 32'h200);
        tick();
        check("lk_idle_a_gnt", A_GNT, 0);
        check("lk_idle_busy", BUSY, 0);
        PROG_LOCK = 1'b0;
        #1;
        check("unlk_a_gnt", A_GNT, 1);
        tick();
        set_a(1'b0, 1'b0, 32'h0, 32'h0);
        PROG_LOCK = 1'b1;
        #1;
        check("lkmid_read", MEM_READ2, 1);
        tick();
        check("lkmid_a_rvalid", A_RVALID, 1);
        check("lkmid_a_rdata", A_RDATA, 32'h55);
        check("lkmid_b_rvalid", B_RVALID, 0);
        tick();
        PROG_LOCK = 1'b0;

        // Reset asserted while a read is in RESP.
        set_a(1'b1, 1'b0, 32'h14, 32'h0);
        #1;
        check("rr_a_gnt", A_GNT, 1);
        tick();
        set_a(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("rr_resp_rvalid", A_RVALID, 1);
        RST_N = 1'b0;
        set_a(1'b1, 1'b0, 32'h14, 32'h0);
        #1;
        check("rr_rst_gnt", A_GNT, 0);
        tick();
        check("rr_after_rvalid", A_RVALID, 0);
        check("rr_after_busy", BUSY, 0);
        check("rr_after_gnt", {A_GNT, B_GNT}, 0);
        check("rr_after_addr", MEM_ADDR2, 0);
        RST_N = 1'b1;
        set_a(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
